// File: rtl/demux_pkt_router_pkg.sv
// demux_pkt_router_pkg
//   Shared definitions for the packet demultiplexer: destination codes,
//   the lock FSM encoding and the default parameter values.
//   No ports; imported by demux_pkt_router and demux_pkt_counter.
package demux_pkt_router_pkg;

    // Destination codes carried in dest_q / lock_sel_q.
    localparam logic DEST_A = 1'b0;
    localparam logic DEST_B = 1'b1;

    // Lock FSM: UNLOCKED samples SEL on every accepted beat,
    // LOCKED reuses the destination captured at the packet's first beat.
    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

    localparam int DEFAULT_SIZE        = 1;
    localparam int DEFAULT_COUNT_WIDTH = 8;

endpackage

// File: rtl/demux_pkt_counter.sv
// demux_pkt_counter
//   Wrap-around event counter used for the per-port delivered-packet count.
//   Ports:
//     CLK    - clock, rising edge
//     RST_N  - synchronous active-low clear
//     INC    - add one this cycle (wraps from all-ones to zero)
//     COUNT  - current count
module demux_pkt_counter
    import demux_pkt_router_pkg::*;
#(
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   INC,
    output logic [COUNT_WIDTH-1:0] COUNT
);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            COUNT <= '0;
        end else if (INC) begin
            // Plain modular add: overflow wraps, never saturates.
            COUNT <= COUNT + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/demux_pkt_router.sv
// demux_pkt_router
//   Registered 1-to-2 demultiplexer with packet lock. One input stream is
//   steered to port A (SEL=0) or port B (SEL=1); the destination chosen at a
//   packet's first beat holds until its LAST beat is accepted.
//
//   Handshake rule (all three interfaces): a beat transfers on a rising edge
//   where VALID=1 and READY=1. While VALID=1 and READY=0 the sender keeps DATA
//   and LAST stable. IN_READY is combinational from the output-side READY so a
//   draining beat and a new beat can swap in the same cycle.
//
//   Ports:
//     CLK, RST_N             - clock, synchronous active-low reset
//     IN_DATA/VALID/LAST     - input beat
//     IN_READY               - input can be accepted this cycle
//     SEL                    - destination for a new packet (0=A, 1=B)
//     OUT_A_DATA/VALID/LAST  - port A beat; OUT_A_READY from consumer A
//     OUT_B_DATA/VALID/LAST  - port B beat; OUT_B_READY from consumer B
//     PKT_CNT_A/B            - wrap-around count of delivered LAST beats
//     LOCKED                 - packet in progress on the input (lock FSM state)
module demux_pkt_router
    import demux_pkt_router_pkg::*;
#(
    parameter int SIZE        = DEFAULT_SIZE,
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [SIZE-1:0]        IN_DATA,
    input  logic                   IN_VALID,
    input  logic                   IN_LAST,
    output logic                   IN_READY,
    input  logic                   SEL,
    output logic [SIZE-1:0]        OUT_A_DATA,
    output logic                   OUT_A_VALID,
    output logic                   OUT_A_LAST,
    input  logic                   OUT_A_READY,
    output logic [SIZE-1:0]        OUT_B_DATA,
    output logic                   OUT_B_VALID,
    output logic                   OUT_B_LAST,
    input  logic                   OUT_B_READY,
    output logic [COUNT_WIDTH-1:0] PKT_CNT_A,
    output logic [COUNT_WIDTH-1:0] PKT_CNT_B,
    output logic                   LOCKED
);

    // Holding register
    logic [SIZE-1:0] data_q;
    logic            last_q;
    logic            dest_q;
    logic            full_q;

    // Packet lock
    lock_state_t     lock_st;
    logic            lock_sel_q;

    logic            dest_ready;
    logic            accept;
    logic            drain;
    logic            route;

    assign dest_ready = (dest_q == DEST_B) ? OUT_B_READY : OUT_A_READY;
    assign IN_READY   = ~full_q | dest_ready;
    assign accept     = IN_VALID & IN_READY;
    assign drain      = full_q & dest_ready;
    assign route      = (lock_st == ST_LOCKED) ? lock_sel_q : SEL;

    // Holding register update. An accept takes priority over a drain: when
    // both happen the new beat simply replaces the departing one.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            data_q <= '0;
            last_q <= 1'b0;
            dest_q <= DEST_A;
            full_q <= 1'b0;
        end else if (accept) begin
            data_q <= IN_DATA;
            last_q <= IN_LAST;
            dest_q <= route;
            full_q <= 1'b1;
        end else if (drain) begin
            // data_q/last_q are kept; outputs are gated by full_q anyway.
            full_q <= 1'b0;
        end
    end

    // Lock FSM
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            lock_st    <= ST_UNLOCKED;
            lock_sel_q <= DEST_A;
        end else begin
            case (lock_st)
                ST_UNLOCKED: begin
                    // Single-beat packets never lock.
                    if (accept && !IN_LAST) begin
                        lock_st    <= ST_LOCKED;
                        lock_sel_q <= SEL;
                    end
                end
                ST_LOCKED: begin
                    if (accept && IN_LAST) begin
                        lock_st <= ST_UNLOCKED;
                    end
                end
                default: lock_st <= ST_UNLOCKED;
            endcase
        end
    end

    assign LOCKED = (lock_st == ST_LOCKED);

    // Output drive: only the port that owns the held beat shows it; the
    // other port (and both ports when empty) drive zeros.
    assign OUT_A_VALID = full_q & (dest_q == DEST_A);
    assign OUT_B_VALID = full_q & (dest_q == DEST_B);
    assign OUT_A_DATA  = OUT_A_VALID ? data_q : '0;
    assign OUT_B_DATA  = OUT_B_VALID ? data_q : '0;
    assign OUT_A_LAST  = OUT_A_VALID & last_q;
    assign OUT_B_LAST  = OUT_B_VALID & last_q;

    // Delivered-packet counters: one tick per LAST-beat output handshake.
    demux_pkt_counter #(
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_cnt_a (
        .CLK   (CLK),
        .RST_N (RST_N),
        .INC   (OUT_A_VALID & OUT_A_READY & OUT_A_LAST),
        .COUNT (PKT_CNT_A)
    );

    demux_pkt_counter #(
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_cnt_b (
        .CLK   (CLK),
        .RST_N (RST_N),
        .INC   (OUT_B_VALID & OUT_B_READY & OUT_B_LAST),
        .COUNT (PKT_CNT_B)
    );

endmodule

// File: tb/tb_demux_pkt_router.sv
// tb_demux_pkt_router
//   Bench for demux_pkt_router at SIZE=8, COUNT_WIDTH=4. Directed scenarios
//   followed by a randomized phase, all compared each cycle against a
//   transaction-level reference model (pending-beat queue, open-packet flag,
//   per-port delivered-packet tallies).
module tb_demux_pkt_router;

    localparam int SIZE        = 8;
    localparam int COUNT_WIDTH = 4;

    // Clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [SIZE-1:0]        in_data;
    logic                   in_valid;
    logic                   in_last;
    logic                   in_ready;
    logic                   sel;
    logic [SIZE-1:0]        out_a_data;
    logic                   out_a_valid;
    logic                   out_a_last;
    logic                   out_a_ready;
    logic [SIZE-1:0]        out_b_data;
    logic                   out_b_valid;
    logic                   out_b_last;
    logic                   out_b_ready;
    logic [COUNT_WIDTH-1:0] pkt_cnt_a;
    logic [COUNT_WIDTH-1:0] pkt_cnt_b;
    logic                   locked;

    demux_pkt_router #(
        .SIZE        (SIZE),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .IN_DATA     (in_data),
        .IN_VALID    (in_valid),
        .IN_LAST     (in_last),
        .IN_READY    (in_ready),
        .SEL         (sel),
        .OUT_A_DATA  (out_a_data),
        .OUT_A_VALID (out_a_valid),
        .OUT_A_LAST  (out_a_last),
        .OUT_A_READY (out_a_ready),
        .OUT_B_DATA  (out_b_data),
        .OUT_B_VALID (out_b_valid),
        .OUT_B_LAST  (out_b_last),
        .OUT_B_READY (out_b_ready),
        .PKT_CNT_A   (pkt_cnt_a),
        .PKT_CNT_B   (pkt_cnt_b),
        .LOCKED      (locked)
    );

    // Scoreboard / reference model
    // Pending beats awaiting delivery, packed as {dest, last, data}.
    logic [SIZE+1:0] exp_q[$];
    logic            pkt_open;
    logic            pkt_dest;
    int              cnt_a_m;
    int              cnt_b_m;
    logic            model_known = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic            full;
        logic [SIZE+1:0] h;
        logic            va;
        logic            vb;
        logic            rdy;
        full = (exp_q.size() != 0);
        h    = full ? exp_q[0] : '0;
        va   = full && (h[SIZE+1] == 1'b0);
        vb   = full && (h[SIZE+1] == 1'b1);
        rdy  = !full || (h[SIZE+1] ? out_b_ready : out_a_ready);
        chk("in_ready",    32'(in_ready),    32'(rdy));
        chk("out_a_valid", 32'(out_a_valid), 32'(va));
        chk("out_b_valid", 32'(out_b_valid), 32'(vb));
        chk("out_a_data",  32'(out_a_data),  va ? 32'(h[SIZE-1:0]) : 32'd0);
        chk("out_b_data",  32'(out_b_data),  vb ? 32'(h[SIZE-1:0]) : 32'd0);
        chk("out_a_last",  32'(out_a_last),  32'(va && h[SIZE]));
        chk("out_b_last",  32'(out_b_last),  32'(vb && h[SIZE]));
        chk("locked",      32'(locked),      32'(pkt_open));
        chk("pkt_cnt_a",   32'(pkt_cnt_a),   32'(cnt_a_m));
        chk("pkt_cnt_b",   32'(pkt_cnt_b),   32'(cnt_b_m));
    endtask

    // Advance the model across the coming rising edge.
    task automatic model_update();
        logic            full;
        logic [SIZE+1:0] h;
        logic            port_rdy;
        logic            drain;
        logic            acc;
        logic            dest;
        if (!rst_n) begin
            exp_q.delete();
            pkt_open    = 1'b0;
            pkt_dest    = 1'b0;
            cnt_a_m     = 0;
            cnt_b_m     = 0;
            model_known = 1'b1;
            return;
        end
        if (!model_known) return;
        full     = (exp_q.size() != 0);
        h        = full ? exp_q[0] : '0;
        port_rdy = h[SIZE+1] ? out_b_ready : out_a_ready;
        drain    = full && port_rdy;
        acc      = in_valid && (!full || port_rdy);
        if (drain) begin
            if (h[SIZE]) begin
                if (h[SIZE+1]) cnt_b_m = (cnt_b_m + 1) % (1 << COUNT_WIDTH);
                else           cnt_a_m = (cnt_a_m + 1) % (1 << COUNT_WIDTH);
            end
            void'(exp_q.pop_front());
        end
        if (acc) begin
            dest = pkt_open ? pkt_dest : sel;
            exp_q.push_back({dest, in_last, in_data});
            if (!pkt_open && !in_last) begin
                pkt_open = 1'b1;
                pkt_dest = sel;
            end else if (pkt_open && in_last) begin
                pkt_open = 1'b0;
            end
        end
    endtask

    // Driver: apply one cycle of inputs, check mid-cycle, step the model.
    task automatic step(input logic v, input logic [SIZE-1:0] d, input logic l,
                        input logic s, input logic ra, input logic rb, input logic rn);
        in_valid    = v;
        in_data     = d;
        in_last     = l;
        sel         = s;
        out_a_ready = ra;
        out_b_ready = rb;
        rst_n       = rn;
        @(negedge clk);
        if (model_known) check_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ra, input logic rb);
        step(1'b0, 8'h00, 1'b0, 1'b0, ra, rb, 1'b1);
    endtask

    initial begin
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; sel = 1'b0;
        out_a_ready = 1'b1; out_b_ready = 1'b1; rst_n = 1'b0;
        @(posedge clk);
        #1;

        // Reset then idle
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1'b1, 1'b1);
        idle(1'b0, 1'b0);

        // 3-beat packet locked to A despite SEL changing to 1
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);

        // Back-to-back single-beat packets to B then A, no bubble
        step(1'b1, 8'hAA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);

        // Back-pressure on port A for 4 cycles
        step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 8'hC3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);

        // 17 single-beat packets to B: counter wraps through zero
        for (int i = 0; i < 17; i++) step(1'b1, 8'(i + 8'h40), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);

        // Reset in the middle of a 4-beat packet to B
        step(1'b1, 8'h61, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 8'h62, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1'b1, 1'b1);
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(1'b1, 1'b1);

        // Gaps inside a locked packet keep the lock
        step(1'b1, 8'h81, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);
        step(1'b1, 8'h82, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(1'b1, 1'b1);

        // Randomized traffic with random back-pressure and rare resets
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 9) < 7),
                 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 99) != 0));
        end
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_pkt_router.md
Name: demux_pkt_router

Overview:
- Registered, scalable 1-to-2 demultiplexer with packet lock; the routing counterpart to the team's 2-to-1 mux.
- Accepts one valid/ready stream and steers each packet to port A (SEL=0) or port B (SEL=1).
- Each output port has its own valid/ready handshake, and each port keeps a wrap-around count of delivered packets.
- Sits between a single producer and two consumers in the datapath.

Parameters:
- SIZE, 1, width of the data path in bits.
- COUNT_WIDTH, 8, width of each delivered-packet counter.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST_N  input  1  synchronous, active-low reset, sampled on the rising edge of CLK.
- IN_DATA  input  SIZE  input beat data.
- IN_VALID  input  1  input beat valid.
- IN_LAST  input  1  marks the final beat of a packet.
- IN_READY  output  1  block can accept a beat this cycle.
- SEL  input  1  destination for a new packet: 0 = port A, 1 = port B.
- OUT_A_DATA  output  SIZE  port A data.
- OUT_A_VALID  output  1  port A beat valid.
- OUT_A_LAST  output  1  port A last beat.
- OUT_A_READY  input  1  port A consumer ready.
- OUT_B_DATA  output  SIZE  port B data.
- OUT_B_VALID  output  1  port B beat valid.
- OUT_B_LAST  output  1  port B last beat.
- OUT_B_READY  input  1  port B consumer ready.
- PKT_CNT_A  output  COUNT_WIDTH  packets delivered on port A.
- PKT_CNT_B  output  COUNT_WIDTH  packets delivered on port B.
- LOCKED  output  1  a packet is in progress on the input; SEL is ignored.

Behaviour:
- State: one holding register (data_q, last_q, dest_q, full_q), packet lock (lock_q, lock_sel_q), two counters.
- Handshakes:
  - Input handshake = IN_VALID & IN_READY.
  - Output handshake on port X = OUT_X_VALID & OUT_X_READY.
  - Data and LAST hold stable while VALID=1 and READY=0.
- IN_READY = ~full_q | dest_ready, where dest_ready = OUT_B_READY if dest_q=1, else OUT_A_READY. This path is combinational and gives full throughput.
- Route on accept: dest = lock_q ? lock_sel_q : SEL.
- Lock FSM, two states:
  - UNLOCKED: an accepted beat with IN_LAST=0 moves to LOCKED and captures lock_sel_q = SEL. An accepted beat with IN_LAST=1 (single-beat packet) stays UNLOCKED.
  - LOCKED: SEL is ignored. An accepted beat with IN_LAST=1 returns to UNLOCKED.
  - LOCKED output = lock_q.
- Latency: a beat accepted at edge N is presented on its port from edge N until its output handshake. Minimum latency is 1 cycle.
- Output drive:
  - OUT_A_VALID = full_q & ~dest_q; OUT_B_VALID = full_q & dest_q.
  - The active port drives data_q and last_q. The inactive port drives all-zero data and LAST=0.
- Register update:
  - Accept with no drain: load, full_q=1.
  - Drain with no accept: full_q=0, data_q is retained.
  - Accept and drain in the same cycle: load new beat, full_q stays 1.
  - Neither: hold.
- Destination switch: back-to-back packets to different ports are legal with no bubble. The new beat loads as the old one drains.
- Counters: PKT_CNT_X increments by 1 on each port-X output handshake with OUT_X_LAST=1. It wraps from 2^COUNT_WIDTH-1 to 0 and never saturates.
- Reset (RST_N=0 at an edge) clears full_q, data_q, last_q, dest_q, lock_q, lock_sel_q and both counters.
  - All outputs are 0 after reset, except IN_READY=1.
  - Reset mid-packet discards the held beat and the lock. The next accepted beat samples SEL afresh.
- IN_VALID=0 cycles within a packet are legal; the lock persists.
- Behaviour is undefined for X/Z on SEL while unlocked.

Decomposition:
- Shared package holds:
  - DEST_A = 1'b0 and DEST_B = 1'b1.
  - Lock FSM encoding: ST_UNLOCKED = 1'b0, ST_LOCKED = 1'b1.
  - Default widths SIZE = 1 and COUNT_WIDTH = 8.
- One sub-module, demux_pkt_counter: COUNT_WIDTH wrap-around counter with synchronous active-low clear and increment enable, instantiated once per port.

Test Plan (SIZE=8, COUNT_WIDTH=4):
- Reset then idle -> all outputs 0 except IN_READY=1. PKT_CNT_A = PKT_CNT_B = 0.
- 3-beat packet 0x11, 0x22, 0x33 (LAST on 0x33). SEL=0 on beat 1, then SEL=1 on beats 2-3. Both ready -> all three beats on port A one cycle after acceptance. Port B stays 0. PKT_CNT_A = 1.
- Back-to-back single-beat packets 0xAA (SEL=1) then 0x55 (SEL=0) in consecutive cycles -> OUT_B shows 0xAA, then OUT_A shows 0x55 the next cycle. No bubble. Each counter = 1.
- OUT_A_READY=0 for 4 cycles while sending 0x5A to port A -> OUT_A_DATA holds 0x5A with VALID=1 and IN_READY=0. Release -> one handshake, IN_READY=1.
- 17 single-beat packets to port B -> PKT_CNT_B wraps 15 -> 0 -> 1.
- RST_N=0 after beat 2 of a 4-beat packet to B -> OUT_B_VALID=0 and LOCKED=0. The next beat with SEL=0 goes to port A.
